// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN (misaligned next PC traps to S_ERR).
package ifetch_pkg;

    // Fetch FSM: request a word, hold it for the core, or park after a trap.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_ERR  = 2'd2
    } ifetch_state_t;

    // Default PC loaded on reset.
    localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;

    // J-type target field location inside the instruction word.
    localparam int unsigned JTGT_LSB = 0;
    localparam int unsigned JTGT_MSB = 25;
    localparam int unsigned JTGT_W   = JTGT_MSB - JTGT_LSB + 1;

    // Upper PC bits that a J-type jump keeps from PC+4 (the 256 MB region).
    localparam int unsigned PC_REGION_W = 32 - JTGT_W - 2;

    // Build a J-type byte target: region bits of PC+4, word index, byte offset 0.
    function automatic logic [31:0] jtype_target(input logic [31:0] pc_plus4,
                                                 input logic [31:0] instr);
        return {pc_plus4[31 -: PC_REGION_W], instr[JTGT_MSB:JTGT_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_npc.sv
// Combinational next-PC selection for the held instruction.
// Priority: jr, then jmp/jal, then taken conditional branch, else sequential.
module ifetch_npc
    import ifetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        branch,
    input  logic        nbranch,
    input  logic        jmp,
    input  logic        jal,
    input  logic        jr,
    input  logic        zero,
    input  logic [31:0] addr_result,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic branch_taken;

    // Sequential address wraps naturally in 32 bits.
    assign pc_plus4     = pc + 32'd4;
    assign branch_taken = (branch & zero) | (nbranch & ~zero);

    // Select the raw next PC; alignment policy is applied by the caller.
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = rs_data;
        end else if (jmp | jal) begin
            next_pc = jtype_target(pc_plus4, instruction);
        end else if (branch_taken) begin
            // Branch target arrives as a word address.
            next_pc = addr_result << 2;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: requests one word at PC, holds it until the core
// advances, then commits the next PC chosen by ifetch_npc.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN. When defined, a misaligned
// next PC is not loaded; fetch_err sets and the FSM parks in S_ERR until
// reset. When undefined, next PC bits [1:0] are forced to zero.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFETCH_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Zero,
    input  logic [31:0] Addr_result,
    input  logic [31:0] Read_data_1,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instruction,
    output logic        inst_valid,
    output logic [31:0] PC,
    output logic [31:0] branch_base_addr,
    output logic [31:0] link_addr,
    output logic        fetch_err
);

    ifetch_state_t state;

    logic [31:0] pc_plus4;
    logic [31:0] npc_raw;
    logic [31:0] npc;
    logic        npc_misaligned;
    logic        commit;

    ifetch_npc u_npc (
        .pc          (PC),
        .instruction (Instruction),
        .branch      (Branch),
        .nbranch     (nBranch),
        .jmp         (Jmp),
        .jal         (Jal),
        .jr          (Jr),
        .zero        (Zero),
        .addr_result (Addr_result),
        .rs_data     (Read_data_1),
        .pc_plus4    (pc_plus4),
        .next_pc     (npc_raw)
    );

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign npc            = npc_raw;
    assign npc_misaligned = |npc_raw[1:0];
`else
    assign npc            = npc_raw & ~32'h0000_0003;
    assign npc_misaligned = 1'b0;
`endif

    // Request is a decode of the state, gated so it drops the instant reset rises.
    assign imem_req         = (state == S_REQ) & ~reset;
    assign imem_addr        = PC;
    assign branch_base_addr = pc_plus4;

    // The held instruction retires only while it is actually held.
    assign commit = (state == S_HOLD) & advance;

    // Fetch FSM with registered PC, instruction, valid and link outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_REQ;
            PC          <= RESET_PC;
            Instruction <= '0;
            inst_valid  <= 1'b0;
            link_addr   <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ready) begin
                        Instruction <= imem_rdata;
                        inst_valid  <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (commit) begin
                        inst_valid <= 1'b0;
                        if (Jal) begin
                            link_addr <= pc_plus4;
                        end
                        if (npc_misaligned) begin
                            // PC keeps the address of the trapping instruction.
                            state <= S_ERR;
                        end else begin
                            PC    <= npc;
                            state <= S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    inst_valid <= 1'b0;
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_err <= 1'b0;
        end else if (commit && npc_misaligned) begin
            fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, corner-case
// sequences and randomized transactions against a transaction-level model.
module tb_ifetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        Branch, nBranch, Jmp, Jal, Jr, Zero;
    logic [31:0] Addr_result, Read_data_1;
    logic        advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic [31:0] PC;
    logic [31:0] branch_base_addr;
    logic [31:0] link_addr;
    logic        fetch_err;

    ifetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .Branch           (Branch),
        .nBranch          (nBranch),
        .Jmp              (Jmp),
        .Jal              (Jal),
        .Jr               (Jr),
        .Zero             (Zero),
        .Addr_result      (Addr_result),
        .Read_data_1      (Read_data_1),
        .advance          (advance),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_ready       (imem_ready),
        .Instruction      (Instruction),
        .inst_valid       (inst_valid),
        .PC               (PC),
        .branch_base_addr (branch_base_addr),
        .link_addr        (link_addr),
        .fetch_err        (fetch_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        branch, nbranch, jmp, jal, jr, zero;
        logic [31:0] addr_result;
        logic [31:0] rd1;
    } ctrl_t;

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] instr;
        ctrl_t       c;
        logic [31:0] exp_pc;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state.
    logic [31:0] m_pc;
    logic [31:0] m_link;
    logic [31:0] m_instr;

    vec_t vecs[13];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, act, exp);
        end
    endtask

    // Drive and sample just after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctrl();
        Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0;
        Addr_result = '0; Read_data_1 = '0; advance = 0;
    endtask

    task automatic apply_ctrl(input ctrl_t c);
        Branch = c.branch; nBranch = c.nbranch; Jmp = c.jmp; Jal = c.jal;
        Jr = c.jr; Zero = c.zero; Addr_result = c.addr_result; Read_data_1 = c.rd1;
    endtask

    function automatic ctrl_t mk_ctrl(input logic [5:0] f, input logic [31:0] ar,
                                      input logic [31:0] rd);
        ctrl_t c;
        {c.branch, c.nbranch, c.jmp, c.jal, c.jr, c.zero} = f;
        c.addr_result = ar;
        c.rd1         = rd;
        return c;
    endfunction

    function automatic vec_t mk_vec(input logic [31:0] pc, input logic [31:0] instr,
                                    input logic [5:0] f, input logic [31:0] ar,
                                    input logic [31:0] rd, input logic [31:0] exp);
        vec_t v;
        v.start_pc = pc;
        v.instr    = instr;
        v.c        = mk_ctrl(f, ar, rd);
        v.exp_pc   = exp;
        return v;
    endfunction

    // Next PC from the written rules, using plain arithmetic.
    function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] instr,
                                              input ctrl_t c);
        logic [31:0] seq;
        logic [31:0] t;
        seq = pc + 32'd4;
        if (c.jr)
            t = c.rd1;
        else if (c.jmp || c.jal)
            t = (seq & 32'hF000_0000) + (instr & 32'h03FF_FFFF) * 32'd4;
        else if (c.zero ? c.branch : c.nbranch)
            t = c.addr_result * 32'd4;
        else
            t = seq;
`ifdef IFETCH_MISALIGN_TRAP_EN
        return t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    // Request at m_pc, stall, then capture a word.
    task automatic fetch(input logic [31:0] word, input int stall, input bit noise);
        check1("req_on", imem_req, 1'b1);
        check32("req_addr", imem_addr, m_pc);
        imem_ready = 0;
        for (int i = 0; i < stall; i++) begin
            if (noise) begin
                // advance outside S_HOLD must be ignored
                advance     = 1'($urandom_range(0, 1));
                Jr          = 1'($urandom_range(0, 1));
                Read_data_1 = $urandom & 32'hFFFF_FFFC;
            end
            imem_rdata = $urandom;
            tick();
            check1("stall_req", imem_req, 1'b1);
            check32("stall_addr", imem_addr, m_pc);
            check1("stall_valid", inst_valid, 1'b0);
        end
        clear_ctrl();
        imem_ready = 1;
        imem_rdata = word;
        tick();
        imem_ready = 0;
        m_instr    = word;
        check1("cap_valid", inst_valid, 1'b1);
        check32("cap_instr", Instruction, word);
        check1("hold_req", imem_req, 1'b0);
        check32("cap_pc", PC, m_pc);
    endtask

    // Hold the instruction, then advance with the given controls.
    task automatic execute(input ctrl_t c, input int hold);
        logic [31:0] exp;
        for (int i = 0; i < hold; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            tick();
            check32("hold_instr", Instruction, m_instr);
            check32("hold_pc", PC, m_pc);
            check1("hold_valid", inst_valid, 1'b1);
            check1("hold_req2", imem_req, 1'b0);
        end
        imem_ready = 0;
        apply_ctrl(c);
        advance = 1;
        exp = model_npc(m_pc, m_instr, c);
        if (c.jal) m_link = m_pc + 32'd4;
        tick();
        clear_ctrl();
        m_pc = exp;
        check1("adv_valid", inst_valid, 1'b0);
        check32("adv_pc", PC, m_pc);
        check32("adv_link", link_addr, m_link);
        check32("adv_bba", branch_base_addr, m_pc + 32'd4);
        check1("adv_ferr", fetch_err, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_t c;
        vecs[0]  = mk_vec(32'h10, 32'h0, 6'b100001, 32'h9, 32'h0, 32'h24);
        vecs[1]  = mk_vec(32'h10, 32'h0, 6'b100000, 32'h9, 32'h0, 32'h14);
        vecs[2]  = mk_vec(32'h20, 32'h0, 6'b010000, 32'h30, 32'h0, 32'hC0);
        vecs[3]  = mk_vec(32'h20, 32'h0, 6'b010001, 32'h30, 32'h0, 32'h24);
        vecs[4]  = mk_vec(32'h40, 32'h0, 6'b000110, 32'h0, 32'h100, 32'h100);
        vecs[5]  = mk_vec(32'h3000_0010, 32'h0800_0040, 6'b001000, 32'h0, 32'h0, 32'h3000_0100);
        vecs[6]  = mk_vec(32'h7FFF_FFFC, 32'h0C00_0010, 6'b000100, 32'h0, 32'h0, 32'h8000_0040);
        vecs[7]  = mk_vec(32'hFFFF_FFFC, 32'h0, 6'b000000, 32'h0, 32'h0, 32'h0);
        vecs[8]  = mk_vec(32'h60, 32'h0, 6'b101011, 32'h5, 32'h200, 32'h200);
        vecs[9]  = mk_vec(32'h70, 32'h0000_0123, 6'b101001, 32'h0, 32'h0, 32'h48C);
        vecs[10] = mk_vec(32'h80, 32'h0, 6'b100001, 32'h4000_0001, 32'h0, 32'h4);
        vecs[11] = mk_vec(32'h90, 32'h0, 6'b110000, 32'h10, 32'h0, 32'h40);
        vecs[12] = mk_vec(32'h90, 32'h0, 6'b110001, 32'h10, 32'h0, 32'h40);

        clear_ctrl();
        imem_ready = 0;
        imem_rdata = '0;
        reset      = 1;
        tick();
        tick();
        check1("rst_req", imem_req, 1'b0);
        check32("rst_pc", PC, 32'h0);
        check32("rst_instr", Instruction, 32'h0);
        check1("rst_valid", inst_valid, 1'b0);
        check32("rst_link", link_addr, 32'h0);
        check1("rst_ferr", fetch_err, 1'b0);

        // First fetch with ready held high.
        reset = 0;
        #1;
        check1("first_req", imem_req, 1'b1);
        check32("first_addr", imem_addr, 32'h0);
        check32("first_bba", branch_base_addr, 32'h4);
        imem_ready = 1;
        imem_rdata = 32'h2008_0005;
        tick();
        imem_ready = 0;
        check1("first_valid", inst_valid, 1'b1);
        check32("first_instr", Instruction, 32'h2008_0005);
        m_pc    = 32'h0;
        m_link  = 32'h0;
        m_instr = 32'h2008_0005;
        execute(mk_ctrl(6'b000000, 32'h0, 32'h0), 1);

        // Directed vectors: steer PC with jr, then fetch and advance the vector.
        for (int i = 0; i < 13; i++) begin
            fetch($urandom, 0, 1'b0);
            execute(mk_ctrl(6'b000010, 32'h0, vecs[i].start_pc), 0);
            fetch(vecs[i].instr, 3, 1'b0);
            execute(vecs[i].c, 1);
            check32("vec_pc", PC, vecs[i].exp_pc);
            check32("vec_addr", imem_addr, vecs[i].exp_pc);
            if (vecs[i].c.jal) check32("vec_link", link_addr, vecs[i].start_pc + 32'd4);
        end

        // Randomized transactions.
        for (int n = 0; n < 150; n++) begin
            fetch($urandom, int'($urandom_range(0, 3)), 1'b1);
            c.branch      = 1'($urandom_range(0, 1));
            c.nbranch     = 1'($urandom_range(0, 1));
            c.zero        = 1'($urandom_range(0, 1));
            c.jmp         = ($urandom_range(0, 3) == 0);
            c.jal         = ($urandom_range(0, 3) == 0);
            c.jr          = ($urandom_range(0, 3) == 0);
            c.addr_result = $urandom;
`ifdef IFETCH_MISALIGN_TRAP_EN
            c.rd1         = $urandom & 32'hFFFF_FFFC;
`else
            c.rd1         = $urandom;
`endif
            execute(c, int'($urandom_range(0, 2)));
        end

        // Reset during a stalled request.
        fetch($urandom, 0, 1'b0);
        execute(mk_ctrl(6'b000010, 32'h0, 32'h500), 0);
        imem_ready = 0;
        tick();
        tick();
        check1("pre_rst_req", imem_req, 1'b1);
        #2;
        reset = 1;
        #1;
        check1("midrst_req", imem_req, 1'b0);
        check32("midrst_pc", PC, 32'h0);
        check1("midrst_valid", inst_valid, 1'b0);
        check32("midrst_link", link_addr, 32'h0);
        tick();
        reset = 0;
        #1;
        check1("postrst_req", imem_req, 1'b1);
        check32("postrst_addr", imem_addr, 32'h0);
        m_pc   = 32'h0;
        m_link = 32'h0;

        // Misaligned jr target.
        fetch($urandom, 1, 1'b0);
        execute(mk_ctrl(6'b000010, 32'h0, 32'h50), 0);
        fetch(32'h0, 0, 1'b0);
`ifdef IFETCH_MISALIGN_TRAP_EN
        Jr          = 1;
        Read_data_1 = 32'h102;
        advance     = 1;
        tick();
        clear_ctrl();
        check1("mis_ferr", fetch_err, 1'b1);
        check1("mis_req", imem_req, 1'b0);
        check1("mis_valid", inst_valid, 1'b0);
        check32("mis_pc", PC, 32'h50);
        imem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            advance = 1;
            tick();
            check1("err_req", imem_req, 1'b0);
            check1("err_ferr", fetch_err, 1'b1);
            check1("err_valid", inst_valid, 1'b0);
        end
        imem_ready = 0;
        clear_ctrl();
`else
        execute(mk_ctrl(6'b000010, 32'h0, 32'h102), 0);
        check32("mis_pc", PC, 32'h100);
        check1("mis_ferr", fetch_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
